// File: rtl/reg_bench_pkg.sv
// Shared defaults and types for the decode-stage register file with scoreboard.
//   DEF_XLEN / DEF_NREGS / DEF_NRD : default data width, register count, read ports
//   DEF_LINK_REG / DEF_LINK_OFFSET : link writeback target and added offset
//   wb_bundle_t                    : one writeback request at default widths
package reg_bench_pkg;

   localparam int DEF_XLEN        = 32;
   localparam int DEF_NREGS       = 32;
   localparam int DEF_NRD         = 3;
   localparam int DEF_AW          = $clog2(DEF_NREGS);
   localparam int DEF_LINK_REG    = 31;
   localparam int DEF_LINK_OFFSET = 4;

   typedef struct packed {
      logic                valid;
      logic [DEF_AW-1:0]   rd;
      logic [DEF_XLEN-1:0] data;
      logic                link;
      logic                set;
      logic                cond;
   } wb_bundle_t;

endpackage

// File: rtl/reg_bench_sb_scoreboard.sv
// Busy-bit scoreboard for the register file.
//   clk, reset_n         : clock, synchronous active-low reset
//   iss_valid, iss_rd    : issue offer (destination register)
//   iss_ready            : offer accepted unless destination is busy and not
//                          being written back this cycle
//   wb_valid, wb_dest    : writeback with its effective destination
//   flush                : clear every busy bit
//   rd_addr              : read addresses, port i = [i*AW +: AW]
//   port_busy            : raw busy bit of each read address (no bypass)
//   pending_cnt          : number of busy bits set
// Handshake: an issue transfers on a cycle where iss_valid and iss_ready are
// both 1; iss_ready does not depend on iss_valid.
module reg_scoreboard
   import reg_bench_pkg::*;
#(
   parameter int NREGS = DEF_NREGS,
   parameter int NRD   = DEF_NRD,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              iss_valid,
   input  logic [AW-1:0]     iss_rd,
   output logic              iss_ready,
   input  logic              wb_valid,
   input  logic [AW-1:0]     wb_dest,
   input  logic              flush,
   input  logic [NRD*AW-1:0] rd_addr,
   output logic [NRD-1:0]    port_busy,
   output logic [AW:0]       pending_cnt
);

   logic [NREGS-1:0] busy;
   logic [NREGS-1:0] busy_nxt;
   logic [AW:0]      cnt_nxt;
   logic             accept;
   logic             wb_clr;
   logic             inc;
   logic             dec;

   assign wb_clr    = wb_valid && (wb_dest != '0);
   assign iss_ready = (iss_rd == '0) || !busy[iss_rd] || (wb_valid && (wb_dest == iss_rd));
   assign accept    = iss_valid && iss_ready && (iss_rd != '0);

   // A same-register issue and writeback leaves the bit set: the clear of
   // the old instruction and the set of the new one cancel in the count.
   assign inc = accept && !busy[iss_rd];
   assign dec = wb_clr && busy[wb_dest] && !(accept && (iss_rd == wb_dest));

   always_comb begin
      busy_nxt = flush ? '0 : busy;
      if (wb_clr) busy_nxt[wb_dest] = 1'b0;
      if (accept) busy_nxt[iss_rd]  = 1'b1;
   end

   always_comb begin
      cnt_nxt = pending_cnt;
      if (flush) cnt_nxt = accept ? (AW+1)'(1) : '0;
      else       cnt_nxt = pending_cnt + (AW+1)'(inc) - (AW+1)'(dec);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         busy        <= '0;
         pending_cnt <= '0;
      end else begin
         busy        <= busy_nxt;
         pending_cnt <= cnt_nxt;
      end
   end

   always_comb begin
      port_busy = '0;
      for (int i = 0; i < NRD; i++) port_busy[i] = busy[rd_addr[i*AW +: AW]];
   end

endmodule

// File: rtl/reg_bench_sb.sv
// Decode-stage register file with writeback bypass and busy scoreboard.
//   clk, reset_n  : clock, synchronous active-low reset
//   rd_addr       : NRD read addresses, port i = [i*AW +: AW]
//   rd_data       : NRD read values, port i = [i*XLEN +: XLEN]
//   rd_busy       : port i reads a register with a pending write
//   iss_valid/iss_rd/iss_ready : issue handshake into the scoreboard
//   wb_valid/wb_rd/wb_data/wb_link/wb_set/wb_cond : writeback request
//   flush         : drop every pending write
//   pending_cnt   : number of busy registers
// Register 0 reads as zero and is never written.
module reg_bench_sb
   import reg_bench_pkg::*;
#(
   parameter int XLEN        = DEF_XLEN,
   parameter int NREGS       = DEF_NREGS,
   parameter int NRD         = DEF_NRD,
   parameter int LINK_REG    = DEF_LINK_REG,
   parameter int LINK_OFFSET = DEF_LINK_OFFSET,
   localparam int AW         = $clog2(NREGS)
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic                iss_valid,
   input  logic [AW-1:0]       iss_rd,
   output logic                iss_ready,
   input  logic                wb_valid,
   input  logic [AW-1:0]       wb_rd,
   input  logic [XLEN-1:0]     wb_data,
   input  logic                wb_link,
   input  logic                wb_set,
   input  logic                wb_cond,
   input  logic                flush,
   output logic [AW:0]         pending_cnt
);

   localparam logic [AW-1:0]   LINK_RD  = AW'(LINK_REG);
   localparam logic [XLEN-1:0] LINK_OFF = XLEN'(LINK_OFFSET);

   logic [XLEN-1:0] regs [NREGS];
   logic [AW-1:0]   wb_dest;
   logic [XLEN-1:0] wb_value;
   logic            wb_write;
   logic [NRD-1:0]  port_busy;

   // Effective destination and value: link beats set beats plain write.
   assign wb_dest  = wb_link ? LINK_RD : wb_rd;
   assign wb_write = wb_valid && (wb_dest != '0);

   always_comb begin
      if (wb_link)     wb_value = wb_data + LINK_OFF;
      else if (wb_set) wb_value = {{(XLEN-1){1'b0}}, wb_cond};
      else             wb_value = wb_data;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int r = 0; r < NREGS; r++) regs[r] <= '0;
      end else if (wb_write) begin
         regs[wb_dest] <= wb_value;
      end
   end

   reg_scoreboard #(
      .NREGS (NREGS),
      .NRD   (NRD),
      .AW    (AW)
   ) u_scoreboard (
      .clk         (clk),
      .reset_n     (reset_n),
      .iss_valid   (iss_valid),
      .iss_rd      (iss_rd),
      .iss_ready   (iss_ready),
      .wb_valid    (wb_valid),
      .wb_dest     (wb_dest),
      .flush       (flush),
      .rd_addr     (rd_addr),
      .port_busy   (port_busy),
      .pending_cnt (pending_cnt)
   );

   // Read ports: x0 first, then write-through bypass, then storage.
   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      for (int i = 0; i < NRD; i++) begin
         if (rd_addr[i*AW +: AW] == '0) begin
            rd_data[i*XLEN +: XLEN] = '0;
            rd_busy[i]              = 1'b0;
         end else if (wb_write && (wb_dest == rd_addr[i*AW +: AW])) begin
            rd_data[i*XLEN +: XLEN] = wb_value;
            rd_busy[i]              = 1'b0;
         end else begin
            rd_data[i*XLEN +: XLEN] = regs[rd_addr[i*AW +: AW]];
            rd_busy[i]              = port_busy[i];
         end
      end
   end

endmodule

// File: tb/tb_reg_bench_sb.sv
module tb_reg_bench_sb;
   import reg_bench_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [14:0] rd_addr;
   logic [95:0] rd_data;
   logic [2:0]  rd_busy;
   logic        iss_valid;
   logic [4:0]  iss_rd;
   logic        iss_ready;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        wb_link;
   logic        wb_set;
   logic        wb_cond;
   logic        flush;
   logic [5:0]  pending_cnt;

   int checks = 0;
   int errors = 0;

   // reference model: architectural state in spec terms
   logic [31:0] model_regs [32];
   bit          model_busy [32];

   always #5 clk = ~clk;

   reg_bench_sb dut (
      .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data),
      .rd_busy(rd_busy), .iss_valid(iss_valid), .iss_rd(iss_rd),
      .iss_ready(iss_ready), .wb_valid(wb_valid), .wb_rd(wb_rd),
      .wb_data(wb_data), .wb_link(wb_link), .wb_set(wb_set),
      .wb_cond(wb_cond), .flush(flush), .pending_cnt(pending_cnt)
   );

   function automatic logic [4:0] m_dest();
      return wb_link ? 5'd31 : wb_rd;
   endfunction

   function automatic logic [31:0] m_value();
      if (wb_link) return wb_data + 32'd4;
      if (wb_set)  return {31'd0, wb_cond};
      return wb_data;
   endfunction

   function automatic bit m_ready(input logic [4:0] r);
      return (r == 0) || !model_busy[r] || (wb_valid && m_dest() == r);
   endfunction

   function automatic int m_count();
      int c = 0;
      for (int r = 0; r < 32; r++) c += model_busy[r];
      return c;
   endfunction

   task automatic m_read(input logic [4:0] a, output logic [31:0] d, output logic b);
      if (a == 0) begin d = 0; b = 0; end
      else if (wb_valid && m_dest() == a) begin d = m_value(); b = 0; end
      else begin d = model_regs[a]; b = model_busy[a]; end
   endtask

   task automatic m_commit();
      bit acc;
      if (!reset_n) begin
         for (int r = 0; r < 32; r++) begin model_regs[r] = 0; model_busy[r] = 0; end
         return;
      end
      acc = iss_valid && m_ready(iss_rd) && iss_rd != 0;
      if (wb_valid && m_dest() != 0) begin
         model_regs[m_dest()] = m_value();
         model_busy[m_dest()] = 0;
      end
      if (flush) for (int r = 0; r < 32; r++) model_busy[r] = 0;
      if (acc) model_busy[iss_rd] = 1;
   endtask

   task automatic idle_inputs();
      iss_valid = 0; iss_rd = 0; wb_valid = 0; wb_rd = 0; wb_data = 0;
      wb_link = 0; wb_set = 0; wb_cond = 0; flush = 0; rd_addr = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      m_commit();
      @(negedge clk);
   endtask

   task automatic set_ports(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
      rd_addr = {a2, a1, a0};
   endtask

   task automatic test_reset();
      reset_n = 0;
      idle_inputs();
      tick();
      reset_n = 1;
      for (int r = 0; r < 32; r++) begin
         set_ports(r[4:0], r[4:0], r[4:0]);
         iss_rd = r[4:0];
         #1;
         for (int p = 0; p < 3; p++) begin
            checks++;
            if (rd_data[p*32 +: 32] !== 32'd0 || rd_busy[p] !== 1'b0) begin
               errors++;
               $display("FAIL reset_read x%0d port%0d: got %h busy %b, want 0 busy 0",
                        r, p, rd_data[p*32 +: 32], rd_busy[p]);
            end
         end
         checks++;
         if (iss_ready !== 1'b1 || pending_cnt !== 6'd0) begin
            errors++;
            $display("FAIL reset_sb x%0d: ready %b cnt %0d, want 1 0", r, iss_ready, pending_cnt);
         end
      end
      idle_inputs();
   endtask

   task automatic test_write_read();
      wb_valid = 1; wb_rd = 5; wb_data = 32'hAA;
      tick();
      idle_inputs();
      set_ports(5, 0, 0);
      #1;
      checks++;
      if (rd_data[31:0] !== 32'hAA) begin
         errors++; $display("FAIL write_read x5: got %h want 000000aa", rd_data[31:0]);
      end
      wb_valid = 1; wb_rd = 5; wb_data = 32'h55;
      set_ports(5, 5, 5);
      #1;
      for (int p = 0; p < 3; p++) begin
         checks++;
         if (rd_data[p*32 +: 32] !== 32'h55 || rd_busy[p] !== 1'b0) begin
            errors++;
            $display("FAIL bypass port%0d: got %h busy %b want 00000055 busy 0",
                     p, rd_data[p*32 +: 32], rd_busy[p]);
         end
      end
      tick();
      wb_valid = 1; wb_rd = 0; wb_data = 32'h1234;
      set_ports(0, 5, 0);
      #1;
      checks++;
      if (rd_data[31:0] !== 32'd0 || rd_data[63:32] !== 32'h55) begin
         errors++; $display("FAIL wb_x0_bypass: got %h %h want 0 55", rd_data[31:0], rd_data[63:32]);
      end
      tick();
      idle_inputs();
      set_ports(0, 0, 0);
      #1;
      checks++;
      if (rd_data[31:0] !== 32'd0) begin
         errors++; $display("FAIL wb_x0: got %h want 0", rd_data[31:0]);
      end
   endtask

   task automatic test_link();
      logic [31:0] x7_before;
      x7_before = model_regs[7];
      wb_valid = 1; wb_link = 1; wb_rd = 7; wb_data = 32'h1000;
      tick();
      idle_inputs();
      set_ports(31, 7, 0);
      #1;
      checks++;
      if (rd_data[31:0] !== 32'h1004 || rd_data[63:32] !== x7_before) begin
         errors++;
         $display("FAIL link: x31 %h x7 %h want 00001004 %h", rd_data[31:0], rd_data[63:32], x7_before);
      end
      wb_valid = 1; wb_link = 1; wb_rd = 3; wb_data = 32'hFFFF_FFFE;
      tick();
      idle_inputs();
      set_ports(31, 0, 0);
      #1;
      checks++;
      if (rd_data[31:0] !== 32'h2) begin
         errors++; $display("FAIL link_wrap: x31 %h want 00000002", rd_data[31:0]);
      end
   endtask

   task automatic test_set();
      wb_valid = 1; wb_set = 1; wb_cond = 1; wb_rd = 9; wb_data = 32'hDEAD;
      tick();
      idle_inputs();
      set_ports(9, 0, 0);
      #1;
      checks++;
      if (rd_data[31:0] !== 32'd1) begin
         errors++; $display("FAIL set_cond1: x9 %h want 00000001", rd_data[31:0]);
      end
      wb_valid = 1; wb_set = 1; wb_cond = 0; wb_rd = 9; wb_data = 32'hDEAD;
      tick();
      idle_inputs();
      set_ports(9, 0, 0);
      #1;
      checks++;
      if (rd_data[31:0] !== 32'd0) begin
         errors++; $display("FAIL set_cond0: x9 %h want 00000000", rd_data[31:0]);
      end
   endtask

   task automatic test_issue();
      iss_valid = 1; iss_rd = 3;
      #1;
      checks++;
      if (iss_ready !== 1'b1) begin
         errors++; $display("FAIL issue_ready_free: got %b want 1", iss_ready);
      end
      tick();
      idle_inputs();
      set_ports(3, 0, 0);
      #1;
      checks++;
      if (rd_busy[0] !== 1'b1 || pending_cnt !== 6'd1) begin
         errors++; $display("FAIL issue_busy: busy %b cnt %0d want 1 1", rd_busy[0], pending_cnt);
      end
      iss_valid = 1; iss_rd = 3;
      #1;
      checks++;
      if (iss_ready !== 1'b0) begin
         errors++; $display("FAIL issue_waw: ready %b want 0", iss_ready);
      end
      tick();
      wb_valid = 1; wb_rd = 3; wb_data = 32'h33;
      #1;
      checks++;
      if (iss_ready !== 1'b1) begin
         errors++; $display("FAIL issue_wb_ready: ready %b want 1", iss_ready);
      end
      tick();
      idle_inputs();
      set_ports(3, 0, 0);
      #1;
      checks++;
      if (rd_busy[0] !== 1'b1 || pending_cnt !== 6'd1 || rd_data[31:0] !== 32'h33) begin
         errors++;
         $display("FAIL issue_wb_same: busy %b cnt %0d data %h want 1 1 00000033",
                  rd_busy[0], pending_cnt, rd_data[31:0]);
      end
      wb_valid = 1; wb_rd = 3; wb_data = 32'h44;
      tick();
      idle_inputs();
      #1;
      checks++;
      if (pending_cnt !== 6'd0) begin
         errors++; $display("FAIL issue_clear: cnt %0d want 0", pending_cnt);
      end
   endtask

   task automatic test_flush_reset();
      for (int r = 3; r <= 5; r++) begin
         iss_valid = 1; iss_rd = r[4:0];
         tick();
      end
      idle_inputs();
      #1;
      checks++;
      if (pending_cnt !== 6'd3) begin
         errors++; $display("FAIL flush_pre: cnt %0d want 3", pending_cnt);
      end
      flush = 1; iss_valid = 1; iss_rd = 6;
      wb_valid = 1; wb_rd = 12; wb_data = 32'hC0FFEE;
      tick();
      idle_inputs();
      set_ports(3, 4, 5);
      #1;
      checks++;
      if (rd_busy !== 3'b000 || pending_cnt !== 6'd1) begin
         errors++; $display("FAIL flush_clear: busy %b cnt %0d want 000 1", rd_busy, pending_cnt);
      end
      set_ports(6, 12, 0);
      #1;
      checks++;
      if (rd_busy[0] !== 1'b1 || rd_data[63:32] !== 32'hC0FFEE) begin
         errors++;
         $display("FAIL flush_keep: x6 busy %b x12 %h want 1 00c0ffee", rd_busy[0], rd_data[63:32]);
      end
      reset_n = 0;
      tick();
      reset_n = 1;
      set_ports(6, 12, 31);
      iss_rd = 6;
      #1;
      checks++;
      if (rd_data !== 96'd0 || rd_busy !== 3'b000 || pending_cnt !== 6'd0 || iss_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset: data %h busy %b cnt %0d ready %b want 0 000 0 1",
                  rd_data, rd_busy, pending_cnt, iss_ready);
      end
      idle_inputs();
   endtask

   task automatic test_random();
      logic [31:0] ed;
      logic        eb;
      for (int n = 0; n < 400; n++) begin
         iss_valid = 1'($urandom_range(0, 1));
         iss_rd    = 5'($urandom_range(0, 7));
         wb_valid  = 1'($urandom_range(0, 1));
         wb_rd     = 5'($urandom_range(0, 7));
         wb_data   = $urandom;
         wb_link   = ($urandom_range(0, 9) == 0);
         wb_set    = ($urandom_range(0, 5) == 0);
         wb_cond   = 1'($urandom_range(0, 1));
         flush     = ($urandom_range(0, 24) == 0);
         set_ports(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
         #1;
         for (int p = 0; p < 3; p++) begin
            m_read(rd_addr[p*5 +: 5], ed, eb);
            checks++;
            if (rd_data[p*32 +: 32] !== ed || rd_busy[p] !== eb) begin
               errors++;
               $display("FAIL rand_read n%0d port%0d x%0d: got %h busy %b want %h busy %b",
                        n, p, rd_addr[p*5 +: 5], rd_data[p*32 +: 32], rd_busy[p], ed, eb);
            end
         end
         checks++;
         if (iss_ready !== m_ready(iss_rd) || pending_cnt !== 6'(m_count())) begin
            errors++;
            $display("FAIL rand_sb n%0d: ready %b cnt %0d want %b %0d",
                     n, iss_ready, pending_cnt, m_ready(iss_rd), m_count());
         end
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      reset_n = 0;
      idle_inputs();
      for (int r = 0; r < 32; r++) begin model_regs[r] = 0; model_busy[r] = 0; end
      @(negedge clk);
      test_reset();
      test_write_read();
      test_link();
      test_set();
      test_issue();
      test_flush_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
